// File: rtl/tbird_led_decoder.sv
// Decodes the T-bird tail-light LED bus back into a lighting mode and flags bad animation.
// Optional step-period measurement is built when TBIRD_DEC_PERIOD_EN is defined.
module tbird_led_decoder #(
    parameter int STEADY_TICKS = 1000,
    parameter int CONFIRM      = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tick,
    input  logic [5:0]  i_leds,
    output logic [2:0]  o_mode,
    output logic        o_mode_valid,
    output logic        o_mode_chg,
    output logic        o_seq_err,
    output logic [15:0] o_step_period
);
    localparam int SW = $clog2(STEADY_TICKS + 1);
    localparam int CW = $clog2(CONFIRM + 1);

    typedef enum logic [2:0] {
        M_OFF    = 3'd0,
        M_LEFT   = 3'd1,
        M_RIGHT  = 3'd2,
        M_HAZ    = 3'd3,
        M_BRAKE  = 3'd4,
        M_LEFTBK = 3'd5,
        M_RGHTBK = 3'd6,
        M_UNK    = 3'd7
    } mode_e;

    logic [5:0]    r_prev;
    logic          r_primed;
    logic [SW-1:0] r_steady;
    logic [CW-1:0] r_conf;
    mode_e         r_cand;
    mode_e         r_mode;
    logic          r_valid;
    logic          r_chg;
    logic          r_err;

    logic [SW-1:0] w_steady;
    logic [CW-1:0] w_conf;
    mode_e         w_cand;
    mode_e         w_mode;
    mode_e         w_kind;
    logic          w_valid;
    logic          w_chg;
    logic          w_err;
    logic          w_primed;
    logic          w_same;

    function automatic logic left_adv(input logic [2:0] a, input logic [2:0] b);
        return (a == 3'b000 && b == 3'b001) || (a == 3'b001 && b == 3'b011) ||
               (a == 3'b011 && b == 3'b111) || (a == 3'b111 && b == 3'b000);
    endfunction

    function automatic logic right_adv(input logic [2:0] a, input logic [2:0] b);
        return (a == 3'b000 && b == 3'b100) || (a == 3'b100 && b == 3'b110) ||
               (a == 3'b110 && b == 3'b111) || (a == 3'b111 && b == 3'b000);
    endfunction

    assign w_same = (i_leds == r_prev);

    // Step kind of the (prev, cur) pair; M_UNK marks an illegal change.
    always_comb begin
        w_kind = M_UNK;
        if ((r_prev == 6'h00 && i_leds == 6'h3f) || (r_prev == 6'h3f && i_leds == 6'h00)) begin
            w_kind = M_HAZ;
        end else if (r_prev[2:0] == i_leds[2:0] && left_adv(r_prev[5:3], i_leds[5:3])) begin
            if (i_leds[2:0] == 3'b000)      w_kind = M_LEFT;
            else if (i_leds[2:0] == 3'b111) w_kind = M_LEFTBK;
        end else if (r_prev[5:3] == i_leds[5:3] && right_adv(r_prev[2:0], i_leds[2:0])) begin
            if (i_leds[5:3] == 3'b000)      w_kind = M_RIGHT;
            else if (i_leds[5:3] == 3'b111) w_kind = M_RGHTBK;
        end
    end

    always_comb begin
        w_primed = r_primed;
        w_steady = r_steady;
        w_conf   = r_conf;
        w_cand   = r_cand;
        w_mode   = r_mode;
        w_valid  = r_valid;
        w_chg    = 1'b0;
        w_err    = 1'b0;
        if (i_tick) begin
            if (!r_primed) begin
                w_primed = 1'b1;
            end else if (w_same) begin
                // Steady actions fire only on the tick the counter first saturates.
                if (r_steady != SW'(STEADY_TICKS)) begin
                    w_steady = r_steady + 1'b1;
                    if (r_steady == SW'(STEADY_TICKS - 1)) begin
                        w_conf = '0;
                        if (i_leds == 6'h00) begin
                            w_mode  = M_OFF;
                            w_valid = 1'b1;
                            w_chg   = (r_mode != M_OFF);
                        end else if (i_leds == 6'h3f) begin
                            w_mode  = M_BRAKE;
                            w_valid = 1'b1;
                            w_chg   = (r_mode != M_BRAKE);
                        end else begin
                            w_mode  = M_UNK;
                            w_valid = 1'b0;
                            w_err   = 1'b1;
                        end
                    end
                end
            end else begin
                w_steady = '0;
                if (w_kind == M_UNK) begin
                    w_err   = 1'b1;
                    w_mode  = M_UNK;
                    w_valid = 1'b0;
                    w_conf  = '0;
                end else begin
                    if (w_kind == r_cand) begin
                        if (r_conf != CW'(CONFIRM)) w_conf = r_conf + 1'b1;
                    end else begin
                        w_cand = w_kind;
                        w_conf = CW'(1);
                    end
                    if (w_conf == CW'(CONFIRM)) begin
                        w_mode  = w_kind;
                        w_valid = 1'b1;
                        w_chg   = (r_mode != w_kind);
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev   <= '0;
            r_primed <= 1'b0;
            r_steady <= '0;
            r_conf   <= '0;
            r_cand   <= M_UNK;
            r_mode   <= M_UNK;
            r_valid  <= 1'b0;
            r_chg    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (i_tick) r_prev <= i_leds;
            r_primed <= w_primed;
            r_steady <= w_steady;
            r_conf   <= w_conf;
            r_cand   <= w_cand;
            r_mode   <= w_mode;
            r_valid  <= w_valid;
            r_chg    <= w_chg;
            r_err    <= w_err;
        end
    end

`ifdef TBIRD_DEC_PERIOD_EN
    logic [15:0] r_pcnt;
    logic [15:0] r_period;

    // Counts sampled ticks since the last legal step; an illegal change restarts from zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pcnt   <= '0;
            r_period <= '0;
        end else if (i_tick && r_primed) begin
            if (!w_same && w_kind != M_UNK) begin
                r_period <= r_pcnt;
                r_pcnt   <= 16'd1;
            end else if (!w_same) begin
                r_pcnt <= '0;
            end else if (r_pcnt != 16'hffff) begin
                r_pcnt <= r_pcnt + 16'd1;
            end
        end
    end

    assign o_step_period = r_period;
`else
    assign o_step_period = '0;
`endif

    assign o_mode       = r_mode;
    assign o_mode_valid = r_valid;
    assign o_mode_chg   = r_chg;
    assign o_seq_err    = r_err;
endmodule

// File: tb/tb_tbird_led_decoder.sv
// Bench for tbird_led_decoder: constant vector table, directed corner sequences,
// and randomized traffic checked against a pattern-level reference model.
module tb_tbird_led_decoder;
    localparam int STEADY = 8;
    localparam int CONF   = 3;
`ifdef TBIRD_DEC_PERIOD_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    localparam logic [3:0][2:0] LSEQ = {3'b111, 3'b011, 3'b001, 3'b000};
    localparam logic [3:0][2:0] RSEQ = {3'b111, 3'b110, 3'b100, 3'b000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [5:0]  leds = '0;
    logic [2:0]  mode;
    logic        mode_valid;
    logic        mode_chg;
    logic        seq_err;
    logic [15:0] step_period;

    int checks = 0;
    int errors = 0;

    tbird_led_decoder #(.STEADY_TICKS(STEADY), .CONFIRM(CONF)) dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_leds(leds),
        .o_mode(mode), .o_mode_valid(mode_valid), .o_mode_chg(mode_chg),
        .o_seq_err(seq_err), .o_step_period(step_period)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks runs of equal samples and a history of recent step kinds.
    bit         m_primed;
    logic [5:0] m_prev;
    int         m_run, m_tickno, m_last, m_bias;
    int         m_mode, m_period;
    bit         m_valid, m_chg, m_err;
    int         m_hist[$];
    int         got_chg;

    function automatic int pos(input logic [3:0][2:0] s, input logic [2:0] x);
        for (int i = 0; i < 4; i++) if (s[i] == x) return i;
        return -1;
    endfunction

    function automatic bit adv(input logic [3:0][2:0] s, input logic [2:0] a, input logic [2:0] b);
        int pa, pb;
        pa = pos(s, a);
        pb = pos(s, b);
        return pa >= 0 && pb == (pa + 1) % 4;
    endfunction

    function automatic int kind_of(input logic [5:0] a, input logic [5:0] b);
        if ((a == 6'h00 && b == 6'h3f) || (a == 6'h3f && b == 6'h00)) return 3;
        if (a[2:0] == b[2:0] && adv(LSEQ, a[5:3], b[5:3])) begin
            if (b[2:0] == 3'b000) return 1;
            if (b[2:0] == 3'b111) return 5;
        end
        if (a[5:3] == b[5:3] && adv(RSEQ, a[2:0], b[2:0])) begin
            if (b[5:3] == 3'b000) return 2;
            if (b[5:3] == 3'b111) return 6;
        end
        return 7;
    endfunction

    task automatic model_reset();
        m_primed = 0; m_prev = '0; m_run = 0; m_tickno = 0; m_last = 0; m_bias = 0;
        m_mode = 7; m_valid = 0; m_period = 0; m_chg = 0; m_err = 0;
        m_hist.delete();
    endtask

    task automatic model_tick(input logic [5:0] v);
        int k;
        bit all_same;
        m_chg = 0;
        m_err = 0;
        if (!m_primed) begin
            m_primed = 1; m_last = m_tickno; m_bias = -1;
        end else if (v == m_prev) begin
            m_run++;
            if (m_run == STEADY) begin
                m_hist.delete();
                if (v == 6'h00 || v == 6'h3f) begin
                    k = (v == 6'h00) ? 0 : 4;
                    m_chg = (m_mode != k);
                    m_mode = k;
                    m_valid = 1;
                end else begin
                    m_err = 1; m_mode = 7; m_valid = 0;
                end
            end
        end else begin
            m_run = 0;
            k = kind_of(m_prev, v);
            if (k == 7) begin
                m_err = 1; m_mode = 7; m_valid = 0;
                m_hist.delete();
                m_last = m_tickno; m_bias = -1;
            end else begin
                m_period = m_tickno - m_last + m_bias;
                if (m_period > 65535) m_period = 65535;
                m_last = m_tickno; m_bias = 0;
                m_hist.push_back(k);
                if (m_hist.size() >= CONF) begin
                    all_same = 1;
                    for (int i = m_hist.size() - CONF; i < m_hist.size(); i++)
                        if (m_hist[i] != k) all_same = 0;
                    if (all_same) begin
                        m_chg = (m_mode != k);
                        m_mode = k;
                        m_valid = 1;
                    end
                end
            end
        end
        m_prev = v;
        m_tickno++;
    endtask

    task automatic pulse(input logic [5:0] v);
        @(negedge clk);
        leds = v;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_tick(input logic [5:0] v);
        pulse(v);
        model_tick(v);
        chk("mode", int'(mode), m_mode);
        chk("mode_valid", int'(mode_valid), int'(m_valid));
        chk("mode_chg", int'(mode_chg), int'(m_chg));
        chk("seq_err", int'(seq_err), int'(m_err));
        chk("step_period", int'(step_period), PEN ? m_period : 0);
        got_chg += int'(mode_chg);
        @(negedge clk);
        chk("chg_width", int'(mode_chg), 0);
        chk("err_width", int'(seq_err), 0);
    endtask

    task automatic rst_dut();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mode", int'(mode), 7);
        chk("rst_valid", int'(mode_valid), 0);
        chk("rst_chg", int'(mode_chg), 0);
        chk("rst_err", int'(seq_err), 0);
        chk("rst_period", int'(step_period), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        got_chg = 0;
    endtask

    typedef struct {
        logic [5:0] leds;
        int         mode;
        bit         vld;
        bit         chg;
        bit         err;
        int         per;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] l, input int m, input bit v, input bit c,
                                input bit e, input int p);
        vec_t r;
        r.leds = l; r.mode = m; r.vld = v; r.chg = c; r.err = e; r.per = p;
        return r;
    endfunction

    vec_t tbl[26];

    initial begin
        logic [5:0] nv;
        int sel, r, n, p;

        // Left animation every 3 ticks, an illegal jump, re-confirmation, then a stuck 011000.
        tbl[0]  = mk(6'b000000, 7, 0, 0, 0, 0);
        tbl[1]  = mk(6'b001000, 7, 0, 0, 0, 0);
        tbl[2]  = mk(6'b001000, 7, 0, 0, 0, 0);
        tbl[3]  = mk(6'b001000, 7, 0, 0, 0, 0);
        tbl[4]  = mk(6'b011000, 7, 0, 0, 0, 3);
        tbl[5]  = mk(6'b011000, 7, 0, 0, 0, 3);
        tbl[6]  = mk(6'b011000, 7, 0, 0, 0, 3);
        tbl[7]  = mk(6'b111000, 1, 1, 1, 0, 3);
        tbl[8]  = mk(6'b111000, 1, 1, 0, 0, 3);
        tbl[9]  = mk(6'b111000, 1, 1, 0, 0, 3);
        tbl[10] = mk(6'b000000, 1, 1, 0, 0, 3);
        tbl[11] = mk(6'b001000, 1, 1, 0, 0, 1);
        tbl[12] = mk(6'b111000, 7, 0, 0, 1, 1);
        tbl[13] = mk(6'b000000, 7, 0, 0, 0, 0);
        tbl[14] = mk(6'b001000, 7, 0, 0, 0, 1);
        tbl[15] = mk(6'b011000, 1, 1, 1, 0, 1);
        for (int i = 16; i < 23; i++) tbl[i] = mk(6'b011000, 1, 1, 0, 0, 1);
        tbl[23] = mk(6'b011000, 7, 0, 0, 1, 1);
        tbl[24] = mk(6'b011000, 7, 0, 0, 0, 1);
        tbl[25] = mk(6'b011000, 7, 0, 0, 0, 1);

        model_reset();
        got_chg = 0;
        repeat (3) @(negedge clk);
        chk("reset_mode", int'(mode), 7);
        chk("reset_valid", int'(mode_valid), 0);
        chk("reset_chg", int'(mode_chg), 0);
        chk("reset_err", int'(seq_err), 0);
        chk("reset_period", int'(step_period), 0);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            pulse(tbl[i].leds);
            chk($sformatf("tbl%0d_mode", i), int'(mode), tbl[i].mode);
            chk($sformatf("tbl%0d_valid", i), int'(mode_valid), int'(tbl[i].vld));
            chk($sformatf("tbl%0d_chg", i), int'(mode_chg), int'(tbl[i].chg));
            chk($sformatf("tbl%0d_err", i), int'(seq_err), int'(tbl[i].err));
            chk($sformatf("tbl%0d_period", i), int'(step_period), PEN ? tbl[i].per : 0);
        end

        // Hazard every 4 ticks, then hold all-on until brake is declared.
        rst_dut();
        for (int s = 0; s < 4; s++) repeat (4) do_tick((s % 2) ? 6'h3f : 6'h00);
        do_tick(6'h3f);
        chk("haz_mode", int'(mode), 3);
        chk("haz_chg_count", got_chg, 1);
        got_chg = 0;
        repeat (STEADY) do_tick(6'h3f);
        chk("brake_mode", int'(mode), 4);
        chk("brake_chg_count", got_chg, 1);

        // Right animation with brake on the left half, then with the left half dark.
        rst_dut();
        do_tick(6'b111000);
        do_tick(6'b111100);
        do_tick(6'b111110);
        do_tick(6'b111111);
        chk("rbk_mode", int'(mode), 6);
        do_tick(6'b111000);
        do_tick(6'b000000);
        do_tick(6'b000100);
        do_tick(6'b000110);
        do_tick(6'b000111);
        chk("right_mode", int'(mode), 2);
        chk("right_valid", int'(mode_valid), 1);

        // Reset after two left steps; the first sample afterwards only primes.
        rst_dut();
        do_tick(6'b000000);
        do_tick(6'b001000);
        do_tick(6'b011000);
        rst_dut();
        do_tick(6'b111000);
        chk("reprime_mode", int'(mode), 7);
        do_tick(6'b000000);
        do_tick(6'b001000);
        chk("reprime_pending", int'(mode_valid), 0);
        do_tick(6'b011000);
        chk("reprime_left", int'(mode), 1);

        // Randomized traffic: sticky step kinds, random glitches and long holds.
        rst_dut();
        sel = 1;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 7) == 0) sel = $urandom_range(0, 4);
            r = $urandom_range(0, 9);
            if (r < 8) begin
                case (sel)
                    0: nv = (m_prev == 6'h3f) ? 6'h00 : 6'h3f;
                    1, 2: begin
                        p = pos(LSEQ, m_prev[5:3]);
                        nv[5:3] = (p < 0) ? 3'b000 : LSEQ[(p + 1) % 4];
                        nv[2:0] = (sel == 2) ? 3'b111 : 3'b000;
                    end
                    default: begin
                        p = pos(RSEQ, m_prev[2:0]);
                        nv[2:0] = (p < 0) ? 3'b000 : RSEQ[(p + 1) % 4];
                        nv[5:3] = (sel == 4) ? 3'b111 : 3'b000;
                    end
                endcase
            end else if (r == 8) begin
                nv = 6'($urandom);
            end else begin
                nv = m_prev;
            end
            do_tick(nv);
            n = (r == 9) ? $urandom_range(STEADY, STEADY + 3) : $urandom_range(0, 3);
            repeat (n) do_tick(nv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tbird_led_decoder.md
Name: tbird_led_decoder

Overview:
- Monitors the 6-bit tail-light LED bus driven by the T-bird lamp controller and decodes it back into the active lighting mode: off, left, right, hazard, brake, left+brake, right+brake.
- Checks the lamp animation for illegal steps and stuck patterns.
- Runs on the system clock, gated by the 1 kHz tick, and sits beside the lamp controller as a self-check and status block.

Parameters:
- STEADY_TICKS, 1000: ticks of unchanged pattern before a steady mode is declared or a stuck error is raised; must exceed the animation step period.
- CONFIRM, 3: consecutive consistent legal steps needed to confirm an animated mode.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- tick  input  1  1 kHz enable, one clk wide; LED bus sampled only when high
- leds  input  6  LED bus: [5]=LC, [4]=LB, [3]=LA (LA is the inner left lamp); [2]=RA, [1]=RB, [0]=RC (RA is the inner right lamp)
- mode  output  3  0=OFF, 1=LEFT, 2=RIGHT, 3=HAZ, 4=BRAKE, 5=LEFT_BK, 6=RIGHT_BK, 7=UNKNOWN
- mode_valid  output  1  mode is confirmed
- mode_chg  output  1  one-clk pulse when a newly confirmed mode differs from the previous one
- seq_err  output  1  one-clk pulse on an illegal transition or a stuck pattern
- step_period  output  16  ticks between the last two legal animation steps (optional feature)

Behaviour:
- Clock and reset:
  - Single clock. Reset is asynchronous and active-high. Reset wins over tick.
  - Reset values: mode=7, mode_valid=0, mode_chg=0, seq_err=0, step_period=0. Internal prev=0, steady count=0, confidence=0, primed=0.
- Sampling:
  - On tick, cur = leds.
  - The first tick after reset only loads prev and sets primed; no classification.
  - Later ticks classify the (prev, cur) pair. Outputs update on the clk edge after the sampling tick (1-clk latency). Then prev = cur.
- Legal step kinds when cur != prev:
  - HAZ step: 000000->111111 or 111111->000000.
  - Left step: leds[5:3] advances 000->001->011->111->000, and leds[2:0] is unchanged and equal to 000 (kind LEFT) or 111 (kind LEFT_BK).
  - Right step: leds[2:0] advances 000->100->110->111->000, and leds[5:3] is unchanged and equal to 000 (kind RIGHT) or 111 (kind RIGHT_BK).
- Confirmation:
  - Legal step of the same kind as the candidate: confidence increments, saturating at CONFIRM.
  - Legal step of a different kind: candidate takes the new kind, confidence=1.
  - When confidence reaches CONFIRM: mode=candidate, mode_valid=1, mode_chg pulses if mode changed.
  - The steady counter clears on every change.
- Illegal change (any change not listed above):
  - seq_err pulse, mode=7, mode_valid=0, confidence=0.
  - A later legal step restarts candidate tracking.
- Steady (cur == prev):
  - Steady counter increments, saturating at STEADY_TICKS.
  - On reaching STEADY_TICKS with pattern 000000: mode=OFF, mode_valid=1.
  - With pattern 111111: mode=BRAKE, mode_valid=1.
  - With any other pattern: seq_err pulse, mode=7, mode_valid=0.
  - Each of these actions occurs once per steady episode. confidence=0.
  - mode_chg applies to steady modes the same way.
- Reaching STEADY_TICKS always overrides an animated mode (for example, animation stops).
- Reset mid-confirmation discards all state; primed must be re-established.

Optional Feature:
- TBIRD_DEC_PERIOD_EN defined:
  - A 16-bit tick counter runs between legal steps, saturating at 0xFFFF.
  - On each legal step, step_period = count, then count restarts at 1.
  - On an illegal change the count clears and step_period is unchanged.
- Not defined: step_period is tied to 0 and no counter is synthesized.

Test Plan:
- Tests run with STEADY_TICKS=8 and CONFIRM=3.
- Left animation: leds 000000,001000,011000,111000,000000, stepping every 3 ticks -> after the 3rd legal step, mode=1, mode_valid=1, mode_chg one pulse. With macro defined, step_period=3.
- Hazard: toggle 000000/111111 every 4 ticks -> mode=3 after 3 steps. Then hold 111111 for 8 ticks -> mode=4, mode_chg pulse.
- Hold leds[5:3]=111 while right animates 000,100,110,111 -> mode=6. Hold leds[5:3]=000 instead -> mode=2.
- During left animation, jump 001000->111000 -> seq_err one clk, mode=7, mode_valid=0. The next 3 legal steps reconfirm mode=1.
- Hold 011000 for 8 ticks -> exactly one seq_err pulse, mode=7. Holding longer produces no further pulses.
- Assert rst after 2 left steps -> all outputs return to reset values immediately. The first tick after release produces no classification. Mode confirms only after 3 new legal steps.
